// File: rtl/mmcm_drp_reconfig_ctrl.sv
// mmcm_drp_reconfig_ctrl
// ----------------------
// Run-time MMCM reconfiguration sequencer. A start request holds the MMCM in
// reset and walks the preset table selected by cfg_sel. Each entry is
// read-modify-written through the DRP; mask bit 1 keeps the current DRP bit.
// After the last entry the MMCM reset is released and LOCKED is awaited.
//
// Ports
//   clk, reset              : clock (also DCLK), synchronous active-high reset
//   start, cfg_sel          : single-cycle request and preset index (IDLE only)
//   busy, done, error       : status; error is sticky until the next start
//   cfg_active              : last preset that loaded and locked successfully
//   locked_sync             : mmcm_locked after a two-flop synchroniser
//   mmcm_rst, mmcm_locked   : MMCM RST output and asynchronous LOCKED input
//   tbl_addr, tbl_data      : preset table port, data valid one cycle after addr
//   drp_*                   : DRP master port
`timescale 1ns/1ps

module mmcm_drp_reconfig_ctrl #(
    parameter int ENTRIES_PER_CFG = 23,
    parameter int CFG_SEL_W       = 2,
    parameter int TBL_ADDR_W      = 7,
    parameter int RST_HOLD        = 4,
    parameter int DRDY_TIMEOUT    = 64,
    parameter int LOCK_TIMEOUT    = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CFG_SEL_W-1:0]  cfg_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [CFG_SEL_W-1:0]  cfg_active,
    output logic                  locked_sync,
    output logic                  mmcm_rst,
    input  logic                  mmcm_locked,
    output logic [TBL_ADDR_W-1:0] tbl_addr,
    input  logic [38:0]           tbl_data,
    output logic [6:0]            drp_daddr,
    output logic                  drp_den,
    output logic                  drp_dwe,
    output logic [15:0]           drp_di,
    input  logic [15:0]           drp_do,
    input  logic                  drp_drdy
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_RST_WAIT  = 4'd1;
    localparam logic [3:0] S_FETCH     = 4'd2;
    localparam logic [3:0] S_RD_REQ    = 4'd3;
    localparam logic [3:0] S_RD_WAIT   = 4'd4;
    localparam logic [3:0] S_WR_REQ    = 4'd5;
    localparam logic [3:0] S_WR_WAIT   = 4'd6;
    localparam logic [3:0] S_RELEASE   = 4'd7;
    localparam logic [3:0] S_LOCK_WAIT = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;
    localparam logic [3:0] S_ERR       = 4'd10;

    localparam int CNT_MAX = (RST_HOLD > DRDY_TIMEOUT) ? RST_HOLD : DRDY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int LOCK_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int IDX_W   = (ENTRIES_PER_CFG > 1) ? $clog2(ENTRIES_PER_CFG) : 1;

    logic [3:0]            state_q,      state_d;
    logic [CFG_SEL_W-1:0]  sel_lat_q,    sel_lat_d;
    logic [IDX_W-1:0]      idx_q,        idx_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic [LOCK_W-1:0]     lock_cnt_q,   lock_cnt_d;
    logic                  fetch_ph_q,   fetch_ph_d;
    logic [31:0]           entry_q,      entry_d;     // {mask, data}
    logic                  busy_q,       busy_d;
    logic                  done_q,       done_d;
    logic                  error_q,      error_d;
    logic [CFG_SEL_W-1:0]  cfg_active_q, cfg_active_d;
    logic                  mmcm_rst_q,   mmcm_rst_d;
    logic [TBL_ADDR_W-1:0] tbl_addr_q,   tbl_addr_d;
    logic [6:0]            daddr_q,      daddr_d;
    logic                  den_q,        den_d;
    logic                  dwe_q,        dwe_d;
    logic [15:0]           di_q,         di_d;
    logic                  sync1_q,      sync2_q;

    // Flat table address of entry idx within preset sel, wrapped to the table width.
    function automatic logic [TBL_ADDR_W-1:0] tbl_addr_of(
        input logic [CFG_SEL_W-1:0] sel,
        input logic [IDX_W-1:0]     idx
    );
        logic [31:0] full;
        full = (32'(sel) * 32'(ENTRIES_PER_CFG)) + 32'(idx);
        return full[TBL_ADDR_W-1:0];
    endfunction

    // Next-state and output-register logic of the reconfiguration sequencer.
    always_comb begin
        state_d      = state_q;
        sel_lat_d    = sel_lat_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        lock_cnt_d   = lock_cnt_q;
        fetch_ph_d   = fetch_ph_q;
        entry_d      = entry_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        cfg_active_d = cfg_active_q;
        mmcm_rst_d   = mmcm_rst_q;
        tbl_addr_d   = tbl_addr_q;
        daddr_d      = daddr_q;
        den_d        = 1'b0;
        dwe_d        = 1'b0;
        di_d         = di_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_lat_d  = cfg_sel;
                    busy_d     = 1'b1;
                    error_d    = 1'b0;
                    mmcm_rst_d = 1'b1;
                    cnt_d      = {CNT_W{1'b0}};
                    state_d    = S_RST_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RST_WAIT: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    idx_d      = {IDX_W{1'b0}};
                    tbl_addr_d = tbl_addr_of(sel_lat_q, {IDX_W{1'b0}});
                    fetch_ph_d = 1'b0;
                    state_d    = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // First FETCH cycle presents the address, second captures the entry.
            S_FETCH: begin
                if (!fetch_ph_q) begin
                    fetch_ph_d = 1'b1;
                end else begin
                    entry_d = tbl_data[31:0];
                    daddr_d = tbl_data[38:32];
                    den_d   = 1'b1;
                    state_d = S_RD_REQ;
                end
            end

            // cnt counts cycles since the enable; the request cycle itself is 0.
            S_RD_REQ: begin
                cnt_d   = CNT_W'(1);
                state_d = S_RD_WAIT;
            end

            // A drdy in the last counted cycle still wins over the timeout.
            S_RD_WAIT: begin
                if (drp_drdy) begin
                    di_d    = (drp_do & entry_q[31:16]) | (entry_q[15:0] & ~entry_q[31:16]);
                    den_d   = 1'b1;
                    dwe_d   = 1'b1;
                    state_d = S_WR_REQ;
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    mmcm_rst_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_WR_REQ: begin
                cnt_d   = CNT_W'(1);
                state_d = S_WR_WAIT;
            end

            S_WR_WAIT: begin
                if (drp_drdy) begin
                    if (idx_q == IDX_W'(ENTRIES_PER_CFG - 1)) begin
                        mmcm_rst_d = 1'b0;
                        state_d    = S_RELEASE;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        tbl_addr_d = tbl_addr_of(sel_lat_q, idx_q + IDX_W'(1));
                        fetch_ph_d = 1'b0;
                        state_d    = S_FETCH;
                    end
                end else if (cnt_q == CNT_W'(DRDY_TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    mmcm_rst_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // lock_cnt counts cycles since the reset release cycle.
            S_RELEASE: begin
                lock_cnt_d = LOCK_W'(1);
                state_d    = S_LOCK_WAIT;
            end

            S_LOCK_WAIT: begin
                if (sync2_q) begin
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    cfg_active_d = sel_lat_q;
                    state_d      = S_DONE;
                end else if (lock_cnt_q >= LOCK_W'(LOCK_TIMEOUT - 1)) begin
                    error_d    = 1'b1;
                    mmcm_rst_d = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = S_ERR;
                end else begin
                    lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                busy_d     = 1'b0;
                mmcm_rst_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            sel_lat_q    <= {CFG_SEL_W{1'b0}};
            idx_q        <= {IDX_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            lock_cnt_q   <= {LOCK_W{1'b0}};
            fetch_ph_q   <= 1'b0;
            entry_q      <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            cfg_active_q <= {CFG_SEL_W{1'b0}};
            mmcm_rst_q   <= 1'b0;
            tbl_addr_q   <= {TBL_ADDR_W{1'b0}};
            daddr_q      <= 7'd0;
            den_q        <= 1'b0;
            dwe_q        <= 1'b0;
            di_q         <= 16'd0;
        end else begin
            state_q      <= state_d;
            sel_lat_q    <= sel_lat_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            fetch_ph_q   <= fetch_ph_d;
            entry_q      <= entry_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            cfg_active_q <= cfg_active_d;
            mmcm_rst_q   <= mmcm_rst_d;
            tbl_addr_q   <= tbl_addr_d;
            daddr_q      <= daddr_d;
            den_q        <= den_d;
            dwe_q        <= dwe_d;
            di_q         <= di_d;
        end
    end

    // Two-flop synchroniser for the asynchronous MMCM LOCKED signal.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mmcm_locked;
            sync2_q <= sync1_q;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign cfg_active  = cfg_active_q;
    assign locked_sync = sync2_q;
    assign mmcm_rst    = mmcm_rst_q;
    assign tbl_addr    = tbl_addr_q;
    assign drp_daddr   = daddr_q;
    assign drp_den     = den_q;
    assign drp_dwe     = dwe_q;
    assign drp_di      = di_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// Testbench for mmcm_drp_reconfig_ctrl: behavioural table/DRP/MMCM models,
// a reference model that predicts table reads, DRP writes and the final
// outcome of each request, and a monitor that checks DUT activity against it.
`timescale 1ns/1ps

module tb_mmcm_drp_reconfig_ctrl;

    localparam int N  = 2;
    localparam int SW = 2;
    localparam int AW = 7;
    localparam int RH = 4;
    localparam int DT = 64;
    localparam int LT = 50;

    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int REF_REL = 0;
    localparam int REF_DEN = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [SW-1:0] cfg_sel = '0;
    logic          busy, done, error, locked_sync, mmcm_rst;
    logic [SW-1:0] cfg_active;
    logic          mmcm_locked = 1'b0;
    logic [AW-1:0] tbl_addr;
    logic [38:0]   tbl_data = '0;
    logic [6:0]    drp_daddr;
    logic          drp_den, drp_dwe;
    logic [15:0]   drp_di;
    logic [15:0]   drp_do = '0;
    logic          drp_drdy = 1'b0;

    mmcm_drp_reconfig_ctrl #(
        .ENTRIES_PER_CFG(N), .CFG_SEL_W(SW), .TBL_ADDR_W(AW),
        .RST_HOLD(RH), .DRDY_TIMEOUT(DT), .LOCK_TIMEOUT(LT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_sel(cfg_sel),
        .busy(busy), .done(done), .error(error), .cfg_active(cfg_active),
        .locked_sync(locked_sync), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe),
        .drp_di(drp_di), .drp_do(drp_do), .drp_drdy(drp_drdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_line(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected or missing event (t=%0t)", name, $time);
    endtask

    // ---------------- environment models ----------------
    logic [38:0] tbl_mem  [0:127];
    logic [15:0] drp_regs [0:127];   // what the MMCM actually holds
    logic [15:0] ref_regs [0:127];   // what the reference model predicts
    logic [AW-1:0] tbl_addr_prev = '0;
    int  drp_lat    = 2;
    bit  drp_mute   = 1'b0;          // reads never answered
    int  lock_delay = 0;             // cycles after release before LOCKED; <0 never
    int  cd         = 0;
    logic [15:0] pend_rdata = '0;
    bit  armed      = 1'b0;
    int  rel_cnt    = 0;

    // Synchronous table ROM, DRP slave with fixed latency, and MMCM lock behaviour.
    always @(negedge clk) begin
        tbl_data      = tbl_mem[tbl_addr_prev];
        tbl_addr_prev = tbl_addr;
        drp_drdy      = 1'b0;
        if (reset) begin
            cd          = 0;
            armed       = 1'b0;
            mmcm_locked = 1'b0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = pend_rdata;
                end
            end
            if (drp_den) begin
                if (drp_dwe) begin
                    drp_regs[drp_daddr] = drp_di;
                    pend_rdata = 16'h0000;
                    cd = drp_lat;
                end else begin
                    pend_rdata = drp_regs[drp_daddr];
                    cd = drp_mute ? 0 : drp_lat;
                end
            end
            if (mmcm_rst) begin
                armed       = 1'b1;
                rel_cnt     = 0;
                mmcm_locked = 1'b0;
            end else if (armed) begin
                if (lock_delay >= 0 && rel_cnt == lock_delay) mmcm_locked = 1'b1;
                rel_cnt++;
            end
        end
    end

    // ---------------- scoreboard queues ----------------
    int exp_tbl[$], exp_rd[$], exp_wr_a[$], exp_wr_d[$];
    int exp_kind[$], exp_cfg[$], exp_ref[$], exp_lat[$];
    int model_cfg = 0;

    task automatic push_evt(input int kind, input int cfg, input int refp, input int lat);
        exp_kind.push_back(kind);
        exp_cfg.push_back(cfg);
        exp_ref.push_back(refp);
        exp_lat.push_back(lat);
    endtask

    task automatic flush_all();
        exp_tbl.delete(); exp_rd.delete(); exp_wr_a.delete(); exp_wr_d.delete();
        exp_kind.delete(); exp_cfg.delete(); exp_ref.delete(); exp_lat.delete();
    endtask

    // Reference model: what one accepted request must produce.
    // A DRP answer L cycles after its enable is accepted while L < DT; a missing
    // answer raises error DT cycles after the enable. LOCKED rising D cycles after
    // release is seen through two sync flops, so success needs D+2 < LT, with done
    // D+3 cycles after release; otherwise error appears LT cycles after release.
    task automatic predict(input int sel, input bit mute, input int lat, input int ldly);
        int a;
        logic [38:0] e;
        logic [6:0]  d;
        logic [15:0] old, wr;
        for (int i = 0; i < N; i++) begin
            a = (sel * N + i) % 128;
            e = tbl_mem[a];
            d = e[38:32];
            exp_tbl.push_back(a);
            exp_rd.push_back(int'(d));
            if (mute || lat >= DT) begin
                push_evt(EV_ERR, model_cfg, REF_DEN, DT);
                return;
            end
            old = ref_regs[d];
            for (int b = 0; b < 16; b++) wr[b] = e[16 + b] ? old[b] : e[b];
            ref_regs[d] = wr;
            exp_wr_a.push_back(int'(d));
            exp_wr_d.push_back(int'(wr));
        end
        if (ldly >= 0 && ldly + 2 < LT) begin
            push_evt(EV_DONE, sel, REF_REL, ldly + 3);
            model_cfg = sel;
        end else begin
            push_evt(EV_ERR, model_cfg, REF_REL, LT);
        end
    endtask

    // ---------------- monitor ----------------
    bit prev_den = 1'b0, prev_done = 1'b0, prev_err = 1'b0, prev_rst = 1'b0;
    int last_den = 0, rel_cyc = 0;
    int m_kind, m_cfg, m_ref, m_lat;

    // Checks DRP traffic, table addresses and completion events against the model.
    always @(negedge clk) begin
        if (reset) begin
            prev_den = 1'b0; prev_done = 1'b0; prev_err = 1'b0; prev_rst = 1'b0;
        end else begin
            if (drp_den) begin
                check("den_back_to_back", {31'd0, prev_den}, 32'd0);
                last_den = cyc;
                if (!drp_dwe) begin
                    if (exp_rd.size() == 0) fail_line("rd_unexpected");
                    else begin
                        check("rd_daddr", {25'd0, drp_daddr}, exp_rd.pop_front());
                        check("tbl_addr", {25'd0, tbl_addr}, exp_tbl.pop_front());
                    end
                end else begin
                    if (exp_wr_a.size() == 0) fail_line("wr_unexpected");
                    else begin
                        check("wr_daddr", {25'd0, drp_daddr}, exp_wr_a.pop_front());
                        check("wr_data", {16'd0, drp_di}, exp_wr_d.pop_front());
                    end
                end
            end
            if (prev_rst && !mmcm_rst) rel_cyc = cyc;
            if (done && prev_done) fail_line("done_wider_than_1");
            if ((done && !prev_done) || (error && !prev_err)) begin
                if (exp_kind.size() == 0) fail_line("evt_unexpected");
                else begin
                    m_kind = exp_kind.pop_front();
                    m_cfg  = exp_cfg.pop_front();
                    m_ref  = exp_ref.pop_front();
                    m_lat  = exp_lat.pop_front();
                    check("evt_kind", done ? EV_DONE : EV_ERR, m_kind);
                    check("evt_cfg_active", {30'd0, cfg_active}, m_cfg);
                    check("evt_busy", {31'd0, busy}, 32'd0);
                    check("evt_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
                    check("evt_latency", (m_ref == REF_DEN) ? cyc - last_den : cyc - rel_cyc, m_lat);
                    check("rd_left", exp_rd.size(), 32'd0);
                    check("wr_left", exp_wr_a.size(), 32'd0);
                end
            end
            prev_den  = drp_den;
            prev_done = done;
            prev_err  = error;
            prev_rst  = mmcm_rst;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int sel, input int lat, input bit mute, input int ldly, input bit poke);
        int k;
        drp_lat = lat; drp_mute = mute; lock_delay = ldly;
        predict(sel, mute, lat, ldly);
        @(negedge clk); cfg_sel = SW'(sel); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_clears_error", {31'd0, error}, 32'd0);
        check("start_mmcm_rst", {31'd0, mmcm_rst}, 32'd1);
        if (poke) begin
            repeat (2) @(negedge clk);
            cfg_sel = 2'd2; start = 1'b1;
            @(negedge clk); start = 1'b0; cfg_sel = SW'(sel);
        end
        k = 0;
        while (busy && k < 5000) begin @(negedge clk); k++; end
        if (busy) fail_line("busy_timeout");
        repeat (3) @(negedge clk);
        check("idle_after_run", {31'd0, busy}, 32'd0);
        check("events_left", exp_kind.size(), 32'd0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 128; i++) begin
            tbl_mem[i]  = {7'($urandom_range(0, 15)), 16'($urandom), 16'($urandom)};
            drp_regs[i] = 16'($urandom);
            ref_regs[i] = drp_regs[i];
        end
        tbl_mem[2]  = {7'h08, 16'h1000, 16'h0041};
        tbl_mem[3]  = {7'h09, 16'hFF00, 16'h1234};
        drp_regs[8] = 16'h1FFF;
        ref_regs[8] = 16'h1FFF;

        // Reset with start held: nothing may start.
        reset = 1'b1; start = 1'b1; cfg_sel = 2'd1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_cfg_active", {30'd0, cfg_active}, 32'd0);
        check("rst_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
        check("rst_locked_sync", {31'd0, locked_sync}, 32'd0);
        check("rst_tbl_addr", {25'd0, tbl_addr}, 32'd0);
        check("rst_drp", {drp_den, drp_dwe, drp_daddr, drp_di}, 32'd0);
        start = 1'b0; reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Directed preset 1 (0x08: 0x1FFF -> 0x1041), lock after 10, ignored start.
        run(1, 2, 1'b0, 10, 1'b1);
        check("cfg_active_1", {30'd0, cfg_active}, 32'd1);
        check("reg8_written", {16'd0, drp_regs[8]}, 32'h1041);

        // First read never answered: error, cfg_active unchanged, no write.
        run(0, 3, 1'b1, 5, 1'b0);
        check("err_sticky", {31'd0, error}, 32'd1);
        // Next successful start clears it.
        run(2, 1, 1'b0, 4, 1'b0);
        check("err_cleared", {31'd0, error}, 32'd0);
        // LOCKED never arrives.
        run(3, 2, 1'b0, -1, 1'b0);
        // Lock boundaries: last accepted and first rejected delay.
        run(1, 1, 1'b0, LT - 3, 1'b0);
        run(0, 1, 1'b0, LT - 2, 1'b0);
        // DRP answer on the last accepted cycle.
        run(2, DT - 1, 1'b0, 3, 1'b0);

        // Reset while waiting for a write to complete.
        drp_lat = 6; drp_mute = 1'b0; lock_delay = 3;
        predict(3, 1'b0, 6, 3);
        @(negedge clk); cfg_sel = 2'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!(drp_den && drp_dwe) && k < 500) begin @(negedge clk); k++; end
        if (!(drp_den && drp_dwe)) fail_line("abort_no_write");
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mmcm_rst", {31'd0, mmcm_rst}, 32'd0);
        check("abort_den", {31'd0, drp_den}, 32'd0);
        @(negedge clk); reset = 1'b0;
        flush_all();
        for (int i = 0; i < 128; i++) ref_regs[i] = drp_regs[i];
        model_cfg = 0;
        run(1, 2, 1'b0, 6, 1'b0);

        // Randomised requests.
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(0, 3), $urandom_range(1, 6), 1'b0, $urandom_range(0, 20), 1'b0);
        end
        check("final_cfg_active", {30'd0, cfg_active}, model_cfg);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
